// File: rtl/enemy_pkg.sv
// Shared constants for the enemy control slice: lanes, FSM encodings, speeds and LFSR taps.
package enemy_pkg;

   localparam logic [1:0] LANE_LEFT  = 2'b00;
   localparam logic [1:0] LANE_MID   = 2'b01;
   localparam logic [1:0] LANE_RIGHT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ROAM    = 3'd1,
      ST_PURSUE  = 3'd2,
      ST_STAGGER = 3'd3,
      ST_KO      = 3'd4
   } ai_state_t;

   localparam logic SPEED_SLOW = 1'b0;
   localparam logic SPEED_FAST = 1'b1;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// 16-bit right-shifting Galois LFSR with enable; a zero state reloads SEED on the next clock.
// rnd_nxt exposes the low bits of the value the register will take when enabled.
module enemy_lfsr
   import enemy_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       en,
   output logic [2:0] rnd_nxt
);

   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   assign lfsr_nxt = lfsr_step(lfsr);
   assign rnd_nxt  = lfsr_nxt[2:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         lfsr <= SEED;
      else if (lfsr == 16'h0000)
         lfsr <= SEED;
      else if (en)
         lfsr <= lfsr_nxt;
   end

endmodule

// File: rtl/enemy_ai.sv
// Enemy control FSM (idle/roam/pursue/stagger/KO) choosing lane, speed and attack per move pulse.
// Optional ENEMY_AI_DIFFICULTY_EN adds difficulty[1:0], shortening ROAM and lengthening PURSUE.
module enemy_ai
   import enemy_pkg::*;
#(
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          AGGRO_MOVES   = 4,
   parameter int          STAGGER_MOVES = 2,
   parameter int          KO_HITS       = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       move,
   input  logic       player_hit,
   input  logic [1:0] player_x_pos,
`ifdef ENEMY_AI_DIFFICULTY_EN
   input  logic [1:0] difficulty,
`endif
   output logic [1:0] x_pos,
   output logic       speed,
   output logic       attack,
   output logic [2:0] ai_state,
   output logic [3:0] hits_taken
);

   localparam logic [4:0] AGGRO_LEN   = 5'(AGGRO_MOVES);
   localparam logic [4:0] STAGGER_LEN = 5'(STAGGER_MOVES);
   localparam logic [3:0] KO_LIMIT    = 4'(KO_HITS);

   ai_state_t  state, state_nxt;
   logic [1:0] x_pos_nxt;
   logic       speed_nxt, attack_nxt;
   logic [3:0] hits_nxt, hits_inc;
   logic [4:0] phase, phase_nxt, phase_inc;
   logic [4:0] roam_len, pursue_len;
   logic [1:0] target;
   logic [2:0] rnd_nxt;
   logic       active;

`ifdef ENEMY_AI_DIFFICULTY_EN
   logic [4:0] roam_shift;
   assign roam_shift = AGGRO_LEN >> difficulty;
   assign roam_len   = (roam_shift == 5'd0) ? 5'd1 : roam_shift;
   assign pursue_len = AGGRO_LEN + {3'b000, difficulty};
`else
   assign roam_len   = AGGRO_LEN;
   assign pursue_len = AGGRO_LEN;
`endif

   assign active    = (state == ST_ROAM) || (state == ST_PURSUE) || (state == ST_STAGGER);
   assign hits_inc  = (hits_taken == 4'hF) ? 4'hF : hits_taken + 4'd1;
   assign phase_inc = phase + 5'd1;
   assign target    = (player_x_pos == 2'b11) ? LANE_MID : player_x_pos;
   assign ai_state  = state;

   // The LFSR advances even when a simultaneous hit suppresses the lane update.
   enemy_lfsr #(.SEED(SEED)) u_lfsr (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (move && active),
      .rnd_nxt (rnd_nxt)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         x_pos      <= LANE_MID;
         speed      <= SPEED_SLOW;
         attack     <= 1'b0;
         hits_taken <= 4'd0;
         phase      <= 5'd0;
      end else begin
         state      <= state_nxt;
         x_pos      <= x_pos_nxt;
         speed      <= speed_nxt;
         attack     <= attack_nxt;
         hits_taken <= hits_nxt;
         phase      <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      x_pos_nxt  = x_pos;
      speed_nxt  = speed;
      attack_nxt = attack;
      hits_nxt   = hits_taken;
      phase_nxt  = phase;
      if (start) begin
         state_nxt  = ST_ROAM;
         x_pos_nxt  = LANE_MID;
         speed_nxt  = SPEED_SLOW;
         attack_nxt = 1'b0;
         hits_nxt   = 4'd0;
         phase_nxt  = 5'd0;
      end else if (player_hit && active) begin
         hits_nxt   = hits_inc;
         speed_nxt  = SPEED_SLOW;
         attack_nxt = 1'b0;
         phase_nxt  = 5'd0;
         if (hits_inc == KO_LIMIT) begin
            state_nxt = ST_KO;
            x_pos_nxt = LANE_MID;
         end else begin
            state_nxt = ST_STAGGER;
         end
      end else if (move) begin
         case (state)
            ST_ROAM: begin
               if (rnd_nxt[1:0] != 2'b11)
                  x_pos_nxt = rnd_nxt[1:0];
               attack_nxt = rnd_nxt[2];
               speed_nxt  = SPEED_SLOW;
               phase_nxt  = phase_inc;
               if (phase_inc == roam_len) begin
                  state_nxt  = ST_PURSUE;
                  phase_nxt  = 5'd0;
                  speed_nxt  = SPEED_FAST;
                  attack_nxt = 1'b1;
               end
            end
            ST_PURSUE: begin
               // One lane per move: left/right never jump straight across.
               if (x_pos < target)
                  x_pos_nxt = x_pos + 2'd1;
               else if (x_pos > target)
                  x_pos_nxt = x_pos - 2'd1;
               phase_nxt = phase_inc;
               if (phase_inc == pursue_len) begin
                  state_nxt  = ST_ROAM;
                  phase_nxt  = 5'd0;
                  speed_nxt  = SPEED_SLOW;
                  attack_nxt = 1'b0;
               end
            end
            ST_STAGGER: begin
               phase_nxt = phase_inc;
               if (phase_inc == STAGGER_LEN) begin
                  state_nxt = ST_ROAM;
                  phase_nxt = 5'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
